// File: rtl/eth_sniffer_pkg.sv
// Shared types and constants for the sniffer receive path.
// Beat layout, framing FSM states and the overflow error marker.
package eth_sniffer_pkg;

   localparam int          ERR_OVERFLOW_BIT = 5;
   localparam logic [5:0]  ERR_OVERFLOW     = 6'b100000;
   localparam int          BEAT_DATA_W      = 32;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic                   sop;
      logic                   eop;
      logic [1:0]             empty;
      logic [5:0]             error;
   } beat_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IN_PKT = 2'd1,
      TERM   = 2'd2,
      SKIP   = 2'd3
   } fifo_state_t;

endpackage

// File: rtl/sniffer_fifo_mem.sv
// Circular beat buffer with show-ahead read; owns pointers and fill level.
// Push is refused when full and pop when empty, so callers may request either freely.
module sniffer_fifo_mem
   import eth_sniffer_pkg::*;
#(
   parameter int  DEPTH  = 8,
   parameter type beat_t = eth_sniffer_pkg::beat_t,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int LVL_W  = PTR_W + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  beat_t            wr_beat_i,
   output beat_t            rd_beat_o,
   output logic [LVL_W-1:0] level_o,
   output logic             full_o,
   output logic             empty_o
);

   beat_t             mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_d;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full_o    = (level_q == LVL_W'(DEPTH));
   assign empty_o   = (level_q == {LVL_W{1'b0}});
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;
   assign rd_beat_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   // Next fill level from the accepted push/pop pair.
   always_comb begin
      level_d = level_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= {LVL_W{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_d;
      end
   end

   // Storage array, written at the write pointer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mem_q <= '{default: '0};
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wr_beat_i;
      end
   end

endmodule

// File: rtl/sniffer_input_fifo.sv
// Receive buffer between the MAC Avalon-ST source and the sniffer controller.
// The MAC cannot stall, so overflow drops whole packets or truncates them with a synthetic eop.
module sniffer_input_fifo
   import eth_sniffer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   input  logic                   in_sop,
   input  logic                   in_eop,
   input  logic [1:0]             in_empty,
   input  logic [5:0]             in_error,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic [1:0]             out_empty,
   output logic [5:0]             out_error,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       drop_count,
   output logic [CNT_W-1:0]       trunc_count
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
      logic [1:0]        empty;
      logic [5:0]        error;
   } wbeat_t;

   localparam wbeat_t TERM_BEAT = '{data: '0, sop: 1'b0, eop: 1'b1, empty: 2'b00, error: ERR_OVERFLOW};

   fifo_state_t       state_q, state_d;
   logic              eop_seen_q, eop_seen_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  trunc_q, trunc_d;
   logic              push_s, pop_s, full_s, empty_s;
   logic              drop_inc_s, trunc_inc_s, term_eop_s;
   wbeat_t            in_beat_s, wr_beat_s, rd_beat_s;

   assign in_beat_s = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty, error: in_error};
   assign pop_s     = out_ready & ~empty_s;

   sniffer_fifo_mem #(
      .DEPTH  (DEPTH),
      .beat_t (wbeat_t)
   ) u_mem (
      .clk       (clk),
      .n_rst     (n_rst),
      .push_i    (push_s),
      .pop_i     (pop_s),
      .wr_beat_i (wr_beat_s),
      .rd_beat_o (rd_beat_s),
      .level_o   (level),
      .full_o    (full_s),
      .empty_o   (empty_s)
   );

   // Framing FSM: decides whether the current beat, a terminator, or nothing is written.
   always_comb begin
      state_d     = state_q;
      eop_seen_d  = eop_seen_q;
      push_s      = 1'b0;
      wr_beat_s   = in_beat_s;
      drop_inc_s  = 1'b0;
      trunc_inc_s = 1'b0;
      term_eop_s  = eop_seen_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_sop) begin
               if (!full_s) begin
                  push_s  = 1'b1;
                  state_d = in_eop ? IDLE : IN_PKT;
               end else begin
                  drop_inc_s = 1'b1;
                  state_d    = in_eop ? IDLE : SKIP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         IN_PKT: begin
            if (in_valid && !full_s) begin
               push_s  = 1'b1;
               state_d = in_eop ? IDLE : IN_PKT;
            end else if (in_valid) begin
               trunc_inc_s = 1'b1;
               eop_seen_d  = in_eop;
               state_d     = TERM;
            end else begin
               state_d = IN_PKT;
            end
         end
         TERM: begin
            // A new sop after the truncated packet ended is a packet we cannot keep.
            if (in_valid && in_sop && eop_seen_q) begin
               drop_inc_s = 1'b1;
               term_eop_s = in_eop;
            end else if (in_valid && in_eop) begin
               term_eop_s = 1'b1;
            end else begin
               term_eop_s = eop_seen_q;
            end
            if (!full_s) begin
               push_s     = 1'b1;
               wr_beat_s  = TERM_BEAT;
               eop_seen_d = 1'b0;
               state_d    = term_eop_s ? IDLE : SKIP;
            end else begin
               eop_seen_d = term_eop_s;
               state_d    = TERM;
            end
         end
         SKIP: begin
            if (in_valid && in_eop) state_d = IDLE;
            else                    state_d = SKIP;
         end
         default: state_d = IDLE;
      endcase
   end

   // Saturating statistics counters.
   always_comb begin
      if (drop_inc_s && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
      else                                          drop_d = drop_q;
      if (trunc_inc_s && (trunc_q != {CNT_W{1'b1}})) trunc_d = trunc_q + CNT_W'(1);
      else                                            trunc_d = trunc_q;
   end

   // FSM and counter registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         eop_seen_q <= 1'b0;
         drop_q     <= {CNT_W{1'b0}};
         trunc_q    <= {CNT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         eop_seen_q <= eop_seen_d;
         drop_q     <= drop_d;
         trunc_q    <= trunc_d;
      end
   end

   assign drop_count  = drop_q;
   assign trunc_count = trunc_q;

   // Head entry drives the outputs; all fields read zero while empty.
   always_comb begin
      if (empty_s) begin
         out_valid = 1'b0;
         out_data  = {DATA_W{1'b0}};
         out_sop   = 1'b0;
         out_eop   = 1'b0;
         out_empty = 2'b00;
         out_error = 6'b000000;
      end else begin
         out_valid = 1'b1;
         out_data  = rd_beat_s.data;
         out_sop   = rd_beat_s.sop;
         out_eop   = rd_beat_s.eop;
         out_empty = rd_beat_s.empty;
         out_error = rd_beat_s.error;
      end
   end

endmodule

// File: tb/tb_sniffer_input_fifo.sv
// Directed bench for sniffer_input_fifo: framing, truncation, drops, reset and saturation.
// A second instance with 3-bit counters shares the stimulus to reach saturation quickly.
module tb_sniffer_input_fifo;
   import eth_sniffer_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic [1:0]  in_empty = 2'b00;
   logic [5:0]  in_error = 6'd0;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_valid, out_sop, out_eop;
   logic [1:0]  out_empty;
   logic [5:0]  out_error;
   logic [3:0]  level;
   logic [15:0] drop_count, trunc_count;

   logic [31:0] s_data;
   logic        s_valid, s_sop, s_eop;
   logic [1:0]  s_empty;
   logic [5:0]  s_error;
   logic [3:0]  s_level;
   logic [2:0]  s_drop, s_trunc;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sniffer_input_fifo #(.DATA_W(32), .DEPTH(8), .CNT_W(16)) dut (
      .clk(clk), .n_rst(n_rst),
      .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_empty(in_empty), .in_error(in_error),
      .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
      .level(level), .drop_count(drop_count), .trunc_count(trunc_count)
   );

   sniffer_input_fifo #(.DATA_W(32), .DEPTH(8), .CNT_W(3)) dut_sat (
      .clk(clk), .n_rst(n_rst),
      .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_empty(in_empty), .in_error(in_error),
      .out_data(s_data), .out_valid(s_valid), .out_sop(s_sop), .out_eop(s_eop),
      .out_empty(s_empty), .out_error(s_error), .out_ready(out_ready),
      .level(s_level), .drop_count(s_drop), .trunc_count(s_trunc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [31:0] d, input logic s, input logic e,
                       input logic [1:0] em, input logic [5:0] er);
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_empty = em; in_error = er;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 32'd0; in_sop = 1'b0; in_eop = 1'b0;
      in_empty = 2'b00; in_error = 6'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      // Reset state
      idle(2);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_trunc", 64'(trunc_count), 64'd0);
      n_rst = 1'b1;
      idle(1);

      // 1: 4-beat packet flowing straight through
      out_ready = 1'b1;
      beat(32'hA000_0000, 1'b1, 1'b0, 2'd0, 6'd0);
      chk("t1_valid0", 64'(out_valid), 64'd1);
      chk("t1_data0", 64'(out_data), 64'hA000_0000);
      chk("t1_sop0", 64'(out_sop), 64'd1);
      chk("t1_level0", 64'(level), 64'd1);
      beat(32'hA000_0001, 1'b0, 1'b0, 2'd0, 6'd0);
      chk("t1_data1", 64'(out_data), 64'hA000_0001);
      chk("t1_sop1", 64'(out_sop), 64'd0);
      beat(32'hA000_0002, 1'b0, 1'b0, 2'd0, 6'd0);
      chk("t1_data2", 64'(out_data), 64'hA000_0002);
      beat(32'hA000_0003, 1'b0, 1'b1, 2'd2, 6'd0);
      chk("t1_data3", 64'(out_data), 64'hA000_0003);
      chk("t1_eop3", 64'(out_eop), 64'd1);
      chk("t1_empty3", 64'(out_empty), 64'd2);
      idle(1);
      chk("t1_level_end", 64'(level), 64'd0);
      chk("t1_valid_end", 64'(out_valid), 64'd0);
      chk("t1_drop", 64'(drop_count), 64'd0);
      chk("t1_trunc", 64'(trunc_count), 64'd0);

      // 2: 10-beat packet into a stalled FIFO truncates after 8
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         beat(32'hB000_0000 + 32'(i), (i == 0), (i == 9), 2'd0, (i == 1) ? 6'h0A : 6'h00);
      chk("t2_level", 64'(level), 64'd8);
      chk("t2_trunc", 64'(trunc_count), 64'd1);
      chk("t2_state", 64'(dut.state_q), 64'(TERM));
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_drain_data", 64'(out_data), 64'hB000_0000 + 64'(i));
         chk("t2_drain_sop", 64'(out_sop), (i == 0) ? 64'd1 : 64'd0);
         if (i == 1) chk("t2_error_kept", 64'(out_error), 64'h0A);
         idle(1);
      end
      chk("t2_term_valid", 64'(out_valid), 64'd1);
      chk("t2_term_data", 64'(out_data), 64'd0);
      chk("t2_term_sop", 64'(out_sop), 64'd0);
      chk("t2_term_eop", 64'(out_eop), 64'd1);
      chk("t2_term_empty", 64'(out_empty), 64'd0);
      chk("t2_term_error", 64'(out_error), 64'h20);
      idle(1);
      chk("t2_level_end", 64'(level), 64'd0);
      chk("t2_state_end", 64'(dut.state_q), 64'(IDLE));

      // 3: whole-packet drop while full, then normal service
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         beat(32'hC000_0000 + 32'(i), (i == 0), (i == 7), 2'd0, 6'd0);
      for (int i = 0; i < 3; i++)
         beat(32'hD000_0000 + 32'(i), (i == 0), (i == 2), 2'd0, 6'd0);
      chk("t3_drop", 64'(drop_count), 64'd1);
      chk("t3_level", 64'(level), 64'd8);
      chk("t3_head", 64'(out_data), 64'hC000_0000);
      chk("t3_state", 64'(dut.state_q), 64'(IDLE));
      out_ready = 1'b1;
      idle(8);
      chk("t3_drained", 64'(level), 64'd0);
      beat(32'hE000_0000, 1'b1, 1'b0, 2'd0, 6'd0);
      chk("t3_e0", 64'(out_data), 64'hE000_0000);
      beat(32'hE000_0001, 1'b0, 1'b1, 2'd1, 6'd0);
      chk("t3_e1", 64'(out_data), 64'hE000_0001);
      chk("t3_e1_eop", 64'(out_eop), 64'd1);
      idle(1);

      // 4a: push+pop at level 8 refuses the push and truncates
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         beat(32'hF000_0000 + 32'(i), (i == 0), 1'b0, 2'd0, 6'd0);
      out_ready = 1'b1;
      beat(32'hF000_0008, 1'b0, 1'b0, 2'd0, 6'd0);
      chk("t4_level_pp", 64'(level), 64'd7);
      chk("t4_trunc", 64'(trunc_count), 64'd2);
      chk("t4_state_term", 64'(dut.state_q), 64'(TERM));
      chk("t4_head", 64'(out_data), 64'hF000_0001);
      beat(32'hF000_0009, 1'b0, 1'b1, 2'd0, 6'd0);
      chk("t4_level_term", 64'(level), 64'd7);
      chk("t4_state_idle", 64'(dut.state_q), 64'(IDLE));
      for (int i = 2; i < 8; i++) begin
         chk("t4_drain", 64'(out_data), 64'hF000_0000 + 64'(i));
         idle(1);
      end
      chk("t4_term_eop", 64'(out_eop), 64'd1);
      chk("t4_term_err", 64'(out_error), 64'h20);
      idle(1);
      chk("t4_empty", 64'(level), 64'd0);

      // 4b: push+pop at level 3 keeps level and order
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         beat(32'h6000_0000 + 32'(i), (i == 0), 1'b0, 2'd0, 6'd0);
      out_ready = 1'b1;
      beat(32'h6000_0003, 1'b0, 1'b0, 2'd0, 6'd0);
      chk("t4b_level", 64'(level), 64'd3);
      chk("t4b_head", 64'(out_data), 64'h6000_0001);
      out_ready = 1'b0;
      beat(32'h6000_0004, 1'b0, 1'b1, 2'd0, 6'd0);
      chk("t4b_level4", 64'(level), 64'd4);
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         chk("t4b_order", 64'(out_data), 64'h6000_0000 + 64'(i));
         idle(1);
      end
      chk("t4b_empty", 64'(level), 64'd0);

      // 5: asynchronous reset mid-packet
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         beat(32'h7000_0000 + 32'(i), (i == 0), 1'b0, 2'd0, 6'd0);
      chk("t5_level_pre", 64'(level), 64'd5);
      n_rst = 1'b0;
      #2;
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_level", 64'(level), 64'd0);
      chk("t5_drop", 64'(drop_count), 64'd0);
      chk("t5_trunc", 64'(trunc_count), 64'd0);
      n_rst = 1'b1;
      idle(1);
      beat(32'h7000_0005, 1'b0, 1'b0, 2'd0, 6'd0);
      beat(32'h7000_0006, 1'b0, 1'b1, 2'd0, 6'd0);
      chk("t5_orphans", 64'(level), 64'd0);
      beat(32'h7100_0000, 1'b1, 1'b1, 2'd0, 6'd0);
      chk("t5_new_level", 64'(level), 64'd1);
      chk("t5_new_data", 64'(out_data), 64'h7100_0000);
      out_ready = 1'b1;
      idle(1);
      chk("t5_empty", 64'(level), 64'd0);

      // 6: drop counter saturation (3-bit instance saturates at 7)
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         beat(32'h8000_0000 + 32'(i), (i == 0), (i == 7), 2'd0, 6'd0);
      for (int i = 0; i < 7; i++)
         beat(32'h9000_0000 + 32'(i), 1'b1, 1'b1, 2'd0, 6'd0);
      chk("t6_drop7", 64'(drop_count), 64'd7);
      chk("t6_sat7", 64'(s_drop), 64'd7);
      for (int i = 0; i < 3; i++)
         beat(32'h9100_0000 + 32'(i), 1'b1, 1'b1, 2'd0, 6'd0);
      chk("t6_drop10", 64'(drop_count), 64'd10);
      chk("t6_sat_hold", 64'(s_drop), 64'd7);
      chk("t6_level", 64'(level), 64'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
